// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back datapath: load alignment/extension and register-file write port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage #(
    parameter int XLEN = 32
`ifdef WB_INSTRET_EN
    ,
    parameter int CNT_W = 64
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_in,
    input  logic            write_to_reg_in,
    input  logic [1:0]      data_to_reg_sel_in,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] alu_out_in,
    input  logic [XLEN-1:0] mem_rdata_in,
    input  logic [2:0]      funct3_in,
    input  logic [1:0]      addr_lo_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            wb_valid
`ifdef WB_INSTRET_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_PC4  = 2'd2;

    logic            valid_q;
    logic            write_to_reg_q;
    logic [1:0]      sel_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] mem_rdata_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic [XLEN-1:0] pc_q;

    // Flush only needs to kill the entry; the payload fields simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= 1'b0;
            write_to_reg_q <= 1'b0;
            sel_q          <= '0;
            rd_q           <= '0;
            alu_q          <= '0;
            mem_rdata_q    <= '0;
            funct3_q       <= '0;
            addr_lo_q      <= '0;
            pc_q           <= '0;
        end else if (flush) begin
            valid_q        <= 1'b0;
            write_to_reg_q <= 1'b0;
        end else if (!stall) begin
            valid_q        <= valid_in;
            write_to_reg_q <= write_to_reg_in;
            sel_q          <= data_to_reg_sel_in;
            rd_q           <= rd_in;
            alu_q          <= alu_out_in;
            mem_rdata_q    <= mem_rdata_in;
            funct3_q       <= funct3_in;
            addr_lo_q      <= addr_lo_in;
            pc_q           <= pc_in;
        end
    end

    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;

    always_comb begin
        load_byte = mem_rdata_q[8*addr_lo_q +: 8];
        load_half = addr_lo_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, load_byte};
            3'b001:  load_data = {{(XLEN-16){load_half[15]}}, load_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, load_half};
            default: load_data = mem_rdata_q;
        endcase
    end

    always_comb begin
        case (sel_q)
            SEL_ALU:  rf_wdata = alu_q;
            SEL_LOAD: rf_wdata = load_data;
            SEL_PC4:  rf_wdata = pc_q + XLEN'(4);
            default:  rf_wdata = '0;
        endcase
    end

    assign rf_we    = valid_q & write_to_reg_q & (rd_q != 5'd0) & (sel_q != 2'd3);
    assign rf_waddr = rd_q;
    assign wb_valid = valid_q;

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (valid_q && !stall) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed write-back cases followed by random traffic,
// checked against a behavioural model of the WB entry.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_in, write_to_reg_in;
    logic [1:0]  data_to_reg_sel_in, addr_lo_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_out_in, mem_rdata_in, pc_in;
    logic [2:0]  funct3_in;
    logic        rf_we, wb_valid;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .write_to_reg_in(write_to_reg_in), .data_to_reg_sel_in(data_to_reg_sel_in),
        .rd_in(rd_in), .alu_out_in(alu_out_in), .mem_rdata_in(mem_rdata_in),
        .funct3_in(funct3_in), .addr_lo_in(addr_lo_in), .pc_in(pc_in),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_valid(wb_valid)
`ifdef WB_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v, w;
        bit [1:0]  sel, alo;
        bit [4:0]  rd;
        bit [2:0]  f3;
        bit [31:0] alu, mem, pc;
    } entry_t;

    typedef struct {
        bit        valid, we, chk;
        bit [4:0]  waddr;
        bit [31:0] wdata;
        bit [63:0] cnt;
    } exp_t;

    entry_t    st;
    bit [63:0] cnt;
    exp_t      sb[$];
    int        checks = 0;
    int        errors = 0;

    function automatic bit [31:0] load_value(bit [31:0] word, bit [2:0] f3, bit [1:0] alo);
        bit [31:0] b, h;
        b = (word >> (8 * alo)) & 32'hFF;
        h = (word >> (alo[1] ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    task automatic step(input bit r, f, s, v, w, input bit [1:0] sel, input bit [4:0] rd,
                        input bit [31:0] alu, mem, input bit [2:0] f3, input bit [1:0] alo,
                        input bit [31:0] pc);
        entry_t nx;
        exp_t   e;
        @(negedge clk);
        rst = r; flush = f; stall = s; valid_in = v; write_to_reg_in = w;
        data_to_reg_sel_in = sel; rd_in = rd; alu_out_in = alu; mem_rdata_in = mem;
        funct3_in = f3; addr_lo_in = alo; pc_in = pc;
        nx = '{v: v, w: w, sel: sel, alo: alo, rd: rd, f3: f3, alu: alu, mem: mem, pc: pc};
        if (r) begin
            st  = '{default: 0};
            cnt = 0;
        end else begin
            if (st.v && !s) cnt = cnt + 1;
            if (f) begin
                st.v = 0;
                st.w = 0;
            end else if (!s) begin
                st = nx;
            end
        end
        e.valid = st.v;
        e.we    = st.v && st.w && (st.rd != 0) && (st.sel != 3);
        e.waddr = st.rd;
        case (st.sel)
            2'd0:    e.wdata = st.alu;
            2'd1:    e.wdata = load_value(st.mem, st.f3, st.alo);
            2'd2:    e.wdata = st.pc + 32'd4;
            default: e.wdata = 32'd0;
        endcase
        e.chk = e.we || r;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic instr(input bit w, input bit [1:0] sel, input bit [4:0] rd,
                         input bit [31:0] alu, mem, input bit [2:0] f3, input bit [1:0] alo,
                         input bit [31:0] pc);
        step(0, 0, 0, 1, w, sel, rd, alu, mem, f3, alo, pc);
    endtask

    task automatic compare(input string name, input bit [63:0] act, input bit [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare("wb_valid", 64'(wb_valid), 64'(e.valid));
                compare("rf_we", 64'(rf_we), 64'(e.we));
                if (e.chk) begin
                    compare("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
                    compare("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
                end
`ifdef WB_INSTRET_EN
                compare("instret", instret, e.cnt);
`endif
            end
        end
    end

    initial begin : driver
        st  = '{default: 0};
        cnt = 0;
        rst = 1; stall = 0; flush = 0; valid_in = 0; write_to_reg_in = 0;
        data_to_reg_sel_in = 0; rd_in = 0; alu_out_in = 0; mem_rdata_in = 0;
        funct3_in = 0; addr_lo_in = 0; pc_in = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 3, 32'hDEAD, 0, 0, 0, 0);
        // ADDI
        instr(1, 0, 5, 32'h0000_1234, 0, 0, 0, 32'h100);
        // loads from 0x80FF_7F01
        instr(1, 1, 2, 0, 32'h80FF_7F01, 3'b000, 2'd3, 32'h104);
        instr(1, 1, 3, 0, 32'h80FF_7F01, 3'b100, 2'd2, 32'h108);
        instr(1, 1, 4, 0, 32'h80FF_7F01, 3'b001, 2'd2, 32'h10C);
        instr(1, 1, 6, 0, 32'h80FF_7F01, 3'b101, 2'd0, 32'h110);
        instr(1, 1, 8, 0, 32'h80FF_7F01, 3'b010, 2'd1, 32'h114);
        instr(1, 1, 9, 0, 32'h80FF_7F01, 3'b111, 2'd3, 32'h118);
        // JAL with PC wrap, then rd=0
        instr(1, 2, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);
        instr(1, 2, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        // store/branch and reserved select
        instr(0, 0, 10, 32'h55, 0, 0, 0, 32'h200);
        instr(1, 3, 11, 32'h66, 0, 0, 0, 32'h204);
        // load then three stalled cycles with fresh inputs
        instr(1, 1, 7, 0, 32'h1234_5678, 3'b000, 2'd1, 32'h300);
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 1, 1, 0, 5'(12 + i), $urandom, $urandom, 3'($urandom), 2'($urandom), $urandom);
        step(0, 1, 1, 1, 1, 0, 13, 32'h77, 0, 0, 0, 0);
        instr(1, 0, 14, 32'h88, 0, 0, 0, 32'h400);
        step(0, 0, 1, 1, 1, 0, 15, 32'h99, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1, 0, 15, 32'h99, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // retirement: 10 instructions, 2 bubbles, 3 stalls
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            if (i == 3 || i == 8)
                step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            else
                instr(1'(i % 2), 0, 5'(i + 1), 32'(i), 0, 0, 0, 32'(4 * i));
            if (i == 5) step(0, 0, 1, 1, 1, 0, 20, 0, 0, 0, 0, 0);
            if (i == 9) begin
                step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 2'($urandom),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom,
                 3'($urandom), 2'($urandom), $urandom);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #3;
        compare("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
